// File: rtl/fir_tx_sequencer_if.sv
// rtl/fir_tx_sequencer_if.sv - symbol handshake between upstream requester and TX sequencer
interface fir_tx_sequencer_if;
  logic i_sym_valid;
  logic i_sym;
  logic o_sym_ready;

  modport master (
    output i_sym_valid,
    output i_sym,
    input  o_sym_ready
  );

  modport slave (
    input  i_sym_valid,
    input  i_sym,
    output o_sym_ready
  );
endinterface

// File: rtl/fir_tx_sequencer.sv
// rtl/fir_tx_sequencer.sv - symbol FIFO and phase-aligned sequencer for the TX polyphase FIR
module fir_tx_sequencer #(
  parameter int OS         = 4,
  parameter int NB_PHASE   = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int NB_PTR     = 3,
  parameter int N_TAPS     = 6,
  parameter int NB_DRAIN   = 5
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_stop,
  fir_tx_sequencer_if.slave   sym,
  output logic                o_fir_data,
  output logic                o_fir_enable,
  output logic                o_fir_valid,
  output logic                o_fir_reset,
  output logic [NB_PHASE-1:0] o_phase,
  output logic                o_busy,
  output logic [NB_PTR:0]     o_fifo_level,
  output logic                o_underrun
);

  localparam logic [NB_PHASE-1:0] PHASE_LAST = NB_PHASE'(OS - 1);
  localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(OS * (N_TAPS - 1) - 1);
  localparam logic [NB_PTR:0]     LEVEL_FULL = (NB_PTR + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [NB_PHASE-1:0] phase, phase_next;
  logic [NB_DRAIN-1:0] drain_cnt, drain_cnt_next;
  logic                fir_data_next;
  logic                stop_req, stop_req_next;
  logic                underrun_next;

  logic [NB_PTR-1:0]   wr_ptr, rd_ptr;
  logic [NB_PTR:0]     level;
  logic                mem [FIFO_DEPTH];

  logic                push, pop;
  logic                fifo_empty, at_boundary, start_ok;

  assign fifo_empty      = (level == '0);
  assign sym.o_sym_ready = (level != LEVEL_FULL);
  assign push            = sym.i_sym_valid && sym.o_sym_ready;
  // The last phase of a symbol is where the next symbol is chosen.
  assign at_boundary     = (phase == PHASE_LAST);
  assign start_ok        = i_start && !fifo_empty && !i_stop;

  assign o_phase      = phase;
  assign o_busy       = (state != ST_IDLE);
  assign o_fifo_level = level;

  // Next-state, pop decision and filter control strobes.
  always_comb begin
    state_next     = state;
    phase_next     = phase;
    drain_cnt_next = drain_cnt;
    fir_data_next  = o_fir_data;
    stop_req_next  = stop_req;
    underrun_next  = o_underrun;
    pop            = 1'b0;
    o_fir_enable   = 1'b0;
    o_fir_valid    = 1'b0;
    o_fir_reset    = 1'b0;

    case (state)
      ST_IDLE: begin
        phase_next     = '0;
        drain_cnt_next = '0;
        if (start_ok) begin
          // Reset the filter now so its phase selector reads 0 in the first RUN cycle.
          o_fir_reset   = 1'b1;
          pop           = 1'b1;
          fir_data_next = mem[rd_ptr];
          stop_req_next = 1'b0;
          state_next    = ST_RUN;
        end
      end

      ST_RUN: begin
        o_fir_enable = 1'b1;
        o_fir_valid  = at_boundary;
        phase_next   = at_boundary ? '0 : phase + 1'b1;
        if (i_stop) begin
          stop_req_next = 1'b1;
        end
        if (at_boundary) begin
          if (stop_req || i_stop) begin
            // Stop wins over a queued symbol; the FIFO keeps what it holds.
            state_next     = ST_DRAIN;
            fir_data_next  = 1'b0;
            drain_cnt_next = '0;
          end else if (!fifo_empty) begin
            pop           = 1'b1;
            fir_data_next = mem[rd_ptr];
          end else begin
            // Starved: a push landing this same cycle is too late to be used.
            underrun_next  = 1'b1;
            state_next     = ST_DRAIN;
            fir_data_next  = 1'b0;
            drain_cnt_next = '0;
          end
        end
      end

      ST_DRAIN: begin
        o_fir_enable   = 1'b1;
        o_fir_valid    = at_boundary;
        fir_data_next  = 1'b0;
        phase_next     = at_boundary ? '0 : phase + 1'b1;
        drain_cnt_next = drain_cnt + 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_next     = ST_IDLE;
          phase_next     = '0;
          drain_cnt_next = '0;
          stop_req_next  = 1'b0;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, phase counter, filter data bit and sticky underrun.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      phase      <= '0;
      drain_cnt  <= '0;
      o_fir_data <= 1'b0;
      stop_req   <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      state      <= state_next;
      phase      <= phase_next;
      drain_cnt  <= drain_cnt_next;
      o_fir_data <= fir_data_next;
      stop_req   <= stop_req_next;
      o_underrun <= underrun_next;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= sym.i_sym;
    end
  end

endmodule
